hdl_tick_sync: RTL and testbench

Cycle-accurate tick generator that sits directly upstream of the testbench's SystemC time-tick call site. It decides on which clock cycles a time tick is issued and holds each tick as a request until the co-simulation side acknowledges it. It provides a programmable tick divider, a tick budget with completion flag, stop control, and an acknowledge timeout, so the HDL clock and SystemC time advance in lock-step with back-pressure.

---
 rtl/hdl_tick_pkg.sv | 31 +++
 rtl/hdl_tick_div.sv | 35 +++
 rtl/hdl_tick_sync.sv | 181 ++++++++++++++++++
 tb/tb_hdl_tick_sync.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdl_tick_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdl_tick_pkg                                                         |
// | Shared state type, default sizing and saturating increment.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hdl_tick_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        HALT     = 3'd4
    } tick_state_t;

    localparam int c_DEF_DIV_W   = 8;
    localparam int c_DEF_CNT_W   = 32;
    localparam int c_DEF_TIMEOUT = 1000;
    localparam int c_SAT_W       = 64;

    // Counters narrower than c_SAT_W are zero-extended in and truncated out.
    function automatic logic [c_SAT_W-1:0] sat_inc(input logic [c_SAT_W-1:0] value,
                                                   input int unsigned        width);
        logic [c_SAT_W-1:0] max_val;
        max_val = {c_SAT_W{1'b1}} >> (c_SAT_W - width);
        return (value >= max_val) ? max_val : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdl_tick_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdl_tick_div                                                         |
// | Loadable down-counter that stops at zero and flags it.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hdl_tick_div
    import hdl_tick_pkg::*;
#(
    parameter int WIDTH = c_DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hdl_tick_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdl_tick_sync                                                        |
// | Divided tick requests with ack handshake, budget, stop and timeout.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hdl_tick_sync
    import hdl_tick_pkg::*;
#(
    parameter int DIV_W   = c_DEF_DIV_W,
    parameter int CNT_W   = c_DEF_CNT_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] budget,
    output logic             tick_req,
    input  logic             tick_ack,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int                    c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LOAD = c_WAIT_W'(TIMEOUT - 1);

    tick_state_t      r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_budget;
    logic             r_stop_pend;
    logic             r_tick_req;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] r_stall;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic             w_start_ok;
    logic             w_in_run;
    logic             w_in_wait;
    logic             w_hs;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_stall_inc;
    logic             w_budget_hit;
    logic             w_stop_any;
    logic             w_run_fire;
    logic             w_stay;
    logic             w_to_run;
    logic             w_div_zero;
    logic             w_wait_zero;
    logic             w_div_load;
    logic [DIV_W-1:0] w_div_val;

    assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == HALT));
    assign w_in_run     = (r_state == RUN);
    assign w_in_wait    = (r_state == WAIT_ACK);
    assign w_hs         = w_in_wait && r_tick_req && tick_ack;
    assign w_cnt_inc    = CNT_W'(sat_inc(c_SAT_W'(r_tick_cnt), CNT_W));
    assign w_stall_inc  = CNT_W'(sat_inc(c_SAT_W'(r_stall), CNT_W));
    assign w_budget_hit = (r_budget != '0) && (w_cnt_inc == r_budget);
    assign w_stop_any   = stop || r_stop_pend;
    assign w_run_fire   = w_in_run && !stop && w_div_zero;
    assign w_stay       = w_hs && !w_budget_hit && !w_stop_any && (r_div == '0);
    assign w_to_run     = w_hs && !w_budget_hit && !w_stop_any && (r_div != '0);

    // The return to RUN loads div-1 because the ack edge already used one cycle.
    assign w_div_load   = w_start_ok || w_to_run;
    assign w_div_val    = w_start_ok ? div : (r_div - 1'b1);

    hdl_tick_div #(
        .WIDTH (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (w_div_load),
        .load_val (w_div_val),
        .en       (w_in_run && !stop),
        .zero     (w_div_zero)
    );

    hdl_tick_div #(
        .WIDTH (c_WAIT_W)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (w_run_fire || w_stay),
        .load_val (c_WAIT_LOAD),
        .en       (w_in_wait && !tick_ack),
        .zero     (w_wait_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_budget    <= '0;
            r_stop_pend <= 1'b0;
            r_tick_req  <= 1'b0;
            r_tick_cnt  <= '0;
            r_stall     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_tick_req && !tick_ack) begin
                r_stall <= w_stall_inc;
            end
            case (r_state)
                IDLE, DONE, HALT: begin
                    if (start) begin
                        r_div       <= div;
                        r_budget    <= budget;
                        r_tick_cnt  <= '0;
                        r_stall     <= '0;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_div_zero) begin
                        r_tick_req <= 1'b1;
                        r_state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tick_ack) begin
                        r_tick_cnt <= w_cnt_inc;
                        if (w_budget_hit) begin
                            r_tick_req  <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_state     <= DONE;
                        end else if (w_stop_any) begin
                            r_tick_req  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_state     <= IDLE;
                        end else if (r_div != '0) begin
                            r_tick_req <= 1'b0;
                            r_state    <= RUN;
                        end
                    end else if (w_wait_zero) begin
                        r_tick_req  <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_state     <= HALT;
                    end else if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                default: begin
                    r_tick_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign tick_req     = r_tick_req;
    assign tick_cnt     = r_tick_cnt;
    assign stall_cycles = r_stall;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hdl_tick_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hdl_tick_sync                                                     |
// | Directed scoreboard bench for hdl_tick_sync.                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hdl_tick_sync;

    localparam int c_DIV_W   = 8;
    localparam int c_CNT_W   = 32;
    localparam int c_TIMEOUT = 8;
    localparam int c_ACK_DLY = 5;

    localparam int c_REQ   = 0;
    localparam int c_CNT   = 1;
    localparam int c_STALL = 2;
    localparam int c_BUSY  = 3;
    localparam int c_DONE  = 4;
    localparam int c_TO    = 5;

    logic               clk     = 1'b0;
    logic               rst     = 1'b0;
    logic               start   = 1'b0;
    logic               stop    = 1'b0;
    logic [c_DIV_W-1:0] div     = '0;
    logic [c_CNT_W-1:0] budget  = '0;
    logic               ack_man = 1'b0;
    logic               ack_dly = 1'b0;
    logic               ack_mode = 1'b0;
    logic               tick_ack;
    logic               tick_req;
    logic [c_CNT_W-1:0] tick_cnt;
    logic [c_CNT_W-1:0] stall_cycles;
    logic               busy;
    logic               done;
    logic               timeout_err;

    assign tick_ack = ack_mode ? ack_dly : ack_man;

    hdl_tick_sync #(
        .DIV_W   (c_DIV_W),
        .CNT_W   (c_CNT_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .budget       (budget),
        .tick_req     (tick_req),
        .tick_ack     (tick_ack),
        .tick_cnt     (tick_cnt),
        .stall_cycles (stall_cycles),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t chk_q[$];
    int   rise_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            c_REQ:   return {31'b0, tick_req};
            c_CNT:   return tick_cnt;
            c_STALL: return stall_cycles;
            c_BUSY:  return {31'b0, busy};
            c_DONE:  return {31'b0, done};
            default: return {31'b0, timeout_err};
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string n);
        chk_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.exp  = v;
        e.name = n;
        chk_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [c_DIV_W-1:0] d, input logic [c_CNT_W-1:0] b);
        div    = d;
        budget = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Checkpoint monitor: compares every scheduled expectation on its cycle.
    always @(negedge clk) begin
        #1;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                compare(chk_q[i].name, get_sig(chk_q[i].sel), chk_q[i].exp);
                chk_q.delete(i);
            end else if (chk_q[i].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: cycle %0d never sampled, expected %0d", chk_q[i].name, chk_q[i].cyc, chk_q[i].exp);
                chk_q.delete(i);
            end
        end
    end

    // Rise monitor: each new tick request must appear on the predicted cycle.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        #1;
        if (tick_req && !prev_req) begin
            if (rise_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected tick_req rise at cycle %0d, expected none", cyc);
            end else begin
                compare("tick_req rise cycle", 32'(cyc), 32'(rise_q.pop_front()));
            end
        end
        prev_req <= tick_req;
    end

    // Delayed responder: acknowledges after c_ACK_DLY stalled cycles.
    int ack_wait = 0;
    always @(negedge clk) begin
        if (ack_dly) begin
            ack_dly  <= 1'b0;
            ack_wait <= 0;
        end else if (ack_mode && tick_req) begin
            if (ack_wait == c_ACK_DLY) ack_dly <= 1'b1;
            else                       ack_wait <= ack_wait + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        int er;

        // Reset state
        for (int s = 0; s < 6; s++) expect_at(2, s, 0, "reset value");
        wait_to(3);
        rst = 1'b1;

        // div=3 budget=4, ack tied high
        ack_man = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 4; k++) rise_q.push_back(e0 + 4 * k);
        expect_at(e0 + 1,  c_BUSY,  1, "t1 busy");
        expect_at(e0 + 16, c_CNT,   3, "t1 cnt before last ack");
        expect_at(e0 + 16, c_DONE,  0, "t1 done before last ack");
        expect_at(e0 + 17, c_CNT,   4, "t1 final cnt");
        expect_at(e0 + 17, c_DONE,  1, "t1 done");
        expect_at(e0 + 17, c_BUSY,  0, "t1 busy after done");
        expect_at(e0 + 17, c_REQ,   0, "t1 req after done");
        expect_at(e0 + 17, c_STALL, 0, "t1 stall");
        pulse_start(8'd3, 32'd4);
        wait_to(e0 + 20);

        // div=0 unlimited: back-to-back ticks, then stop pending in WAIT_ACK
        e0 = cyc + 1;
        rise_q.push_back(e0 + 1);
        for (int c = 1; c <= 12; c++) expect_at(e0 + c, c_REQ, 1, "t2 req continuous");
        expect_at(e0 + 11, c_CNT,   10, "t2 cnt after 10 acks");
        expect_at(e0 + 11, c_STALL, 0,  "t2 stall");
        expect_at(e0 + 11, c_DONE,  0,  "t2 done cleared");
        expect_at(e0 + 13, c_CNT,   11, "t2 cnt after stop");
        expect_at(e0 + 13, c_STALL, 1,  "t2 stall after stop");
        expect_at(e0 + 13, c_BUSY,  0,  "t2 busy after stop");
        expect_at(e0 + 13, c_DONE,  0,  "t2 done after stop");
        expect_at(e0 + 13, c_REQ,   0,  "t2 req after stop");
        pulse_start(8'd0, 32'd0);
        wait_to(e0 + 11);
        ack_man = 1'b0;
        stop    = 1'b1;
        @(negedge clk);
        stop    = 1'b0;
        ack_man = 1'b1;
        wait_to(e0 + 15);

        // div=2 budget=3, ack delayed 5 cycles per request
        ack_man  = 1'b0;
        ack_mode = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 3; k++) begin
            er = e0 + 3 + 8 * (k - 1);
            rise_q.push_back(er);
            expect_at(er + 5, c_REQ,   1,     "t3 req held before ack");
            expect_at(er + 5, c_CNT,   k - 1, "t3 cnt before ack");
            expect_at(er + 6, c_CNT,   k,     "t3 cnt after ack");
            expect_at(er + 6, c_STALL, 5 * k, "t3 stall");
        end
        expect_at(e0 + 9,  c_REQ,  0, "t3 req dropped after ack");
        expect_at(e0 + 25, c_DONE, 1, "t3 done");
        expect_at(e0 + 25, c_BUSY, 0, "t3 busy");
        pulse_start(8'd2, 32'd3);
        wait_to(e0 + 28);
        ack_mode = 1'b0;

        // Timeout with ack held low, then restart clears the error
        e0 = cyc + 1;
        er = e0 + 2;
        rise_q.push_back(er);
        expect_at(er + 7, c_REQ,   1, "t4 req before timeout");
        expect_at(er + 7, c_TO,    0, "t4 no timeout yet");
        expect_at(er + 8, c_TO,    1, "t4 timeout_err");
        expect_at(er + 8, c_REQ,   0, "t4 req after timeout");
        expect_at(er + 8, c_BUSY,  0, "t4 busy in HALT");
        expect_at(er + 8, c_STALL, 8, "t4 stall");
        expect_at(er + 8, c_CNT,   0, "t4 cnt");
        pulse_start(8'd1, 32'd0);
        wait_to(er + 10);
        e1 = cyc + 1;
        expect_at(e1,     c_TO,    0, "t4 restart clears timeout");
        expect_at(e1,     c_STALL, 0, "t4 restart clears stall");
        expect_at(e1,     c_BUSY,  1, "t4 restart busy");
        expect_at(e1 + 1, c_BUSY,  0, "t4 stop in RUN busy");
        expect_at(e1 + 1, c_DONE,  0, "t4 stop in RUN done");
        expect_at(e1 + 1, c_REQ,   0, "t4 stop in RUN req");
        pulse_start(8'd1, 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(e1 + 3);

        // Stop in WAIT_ACK, acknowledge three cycles later
        ack_man = 1'b1;
        e0 = cyc + 1;
        rise_q.push_back(e0 + 2);
        rise_q.push_back(e0 + 4);
        expect_at(e0 + 3, c_CNT,   1, "t5 first tick");
        expect_at(e0 + 7, c_REQ,   1, "t5 req held with stop pending");
        expect_at(e0 + 7, c_BUSY,  1, "t5 busy with stop pending");
        expect_at(e0 + 7, c_CNT,   1, "t5 cnt with stop pending");
        expect_at(e0 + 8, c_CNT,   2, "t5 cnt after late ack");
        expect_at(e0 + 8, c_BUSY,  0, "t5 busy after stop");
        expect_at(e0 + 8, c_DONE,  0, "t5 done after stop");
        expect_at(e0 + 8, c_REQ,   0, "t5 req after stop");
        expect_at(e0 + 8, c_STALL, 3, "t5 stall");
        pulse_start(8'd1, 32'd0);
        wait_to(e0 + 3);
        ack_man = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(e0 + 7);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;

        // Stop in RUN keeps tick_cnt; ack while req low is ignored
        ack_man = 1'b1;
        e0 = cyc + 1;
        rise_q.push_back(e0 + 6);
        expect_at(e0 + 8, c_CNT,  1, "t6 cnt in RUN");
        expect_at(e0 + 8, c_BUSY, 1, "t6 busy in RUN");
        expect_at(e0 + 9, c_BUSY, 0, "t6 busy after stop");
        expect_at(e0 + 9, c_CNT,  1, "t6 cnt unchanged");
        expect_at(e0 + 9, c_DONE, 0, "t6 done after stop");
        expect_at(e0 + 9, c_REQ,  0, "t6 req after stop");
        pulse_start(8'd5, 32'd0);
        wait_to(e0 + 8);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(e0 + 11);

        // Asynchronous reset in WAIT_ACK
        e0 = cyc + 1;
        rise_q.push_back(e0 + 1);
        expect_at(e0 + 3, c_CNT,   2, "t7 cnt before reset");
        expect_at(e0 + 4, c_STALL, 1, "t7 stall before reset");
        expect_at(e0 + 4, c_REQ,   1, "t7 req before reset");
        expect_at(e0 + 4, c_BUSY,  1, "t7 busy before reset");
        for (int s = 0; s < 6; s++) expect_at(e0 + 5, s, 0, "t7 async reset value");
        pulse_start(8'd0, 32'd0);
        wait_to(e0 + 3);
        ack_man = 1'b0;
        wait_to(e0 + 5);
        rst = 1'b0;
        wait_to(e0 + 7);
        rst = 1'b1;

        // Start ignored while busy, restart from DONE
        ack_man = 1'b1;
        e0 = cyc + 1;
        rise_q.push_back(e0 + 2);
        rise_q.push_back(e0 + 4);
        expect_at(e0 + 5, c_CNT,  2, "t8 cnt at done");
        expect_at(e0 + 5, c_DONE, 1, "t8 done");
        expect_at(e0 + 5, c_BUSY, 0, "t8 busy at done");
        expect_at(e0 + 7, c_DONE, 1, "t8 done held");
        pulse_start(8'd1, 32'd2);
        wait_to(e0 + 1);
        pulse_start(8'd7, 32'd9);
        wait_to(e0 + 7);
        e1 = cyc + 1;
        rise_q.push_back(e1 + 1);
        expect_at(e1,     c_CNT,  0, "t8 restart clears cnt");
        expect_at(e1,     c_DONE, 0, "t8 restart clears done");
        expect_at(e1,     c_BUSY, 1, "t8 restart busy");
        expect_at(e1 + 2, c_CNT,  1, "t8 restart cnt");
        expect_at(e1 + 2, c_DONE, 1, "t8 restart done");
        pulse_start(8'd0, 32'd1);
        wait_to(e1 + 4);

        compare("pending checkpoints", 32'(chk_q.size()), 0);
        compare("pending tick rises", 32'(rise_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
